// File: rtl/drp_sample_responder.sv
// ---------------------------------------------------------------------------
// drp_sample_responder
//
// DRP slave that exposes two auxiliary-channel conversion results, a sticky
// overrun status word and two read/write configuration registers. Each DRP
// request is accepted in IDLE and completes a fixed RD_LATENCY cycles later
// with a single-cycle drdy_out strobe. Conversion samples arrive on a
// separate strobe and are written regardless of DRP activity.
//
// Ports
//   clk           DRP clock; all logic runs on it
//   reset         asynchronous, active-low reset
//   daddr_in      DRP register address (7 bits)
//   den_in        DRP request; may be held high by the initiator
//   dwe_in        DRP write enable, qualified by den_in
//   di_in         DRP write data (16 bits)
//   do_out        DRP read data, held until the next read completes
//   drdy_out      one-cycle transaction-complete strobe
//   sample_valid  new conversion sample strobe
//   sample_chan   0 = VAUX3 (EMG), 1 = VAUX11 (ECG)
//   sample_data   unsigned 12-bit conversion result
//   busy_out      high while a transaction is in flight
//
// Register map
//   0x13  VAUX3 result  {sample, 4'b0000}, read-only
//   0x1B  VAUX11 result {sample, 4'b0000}, read-only
//   0x3F  status: bit0 VAUX3 overrun, bit1 VAUX11 overrun; clear-on-read
//   0x40  config 0, read/write
//   0x41  config 1, read/write
//   other addresses read 0x0000, writes ignored
// ---------------------------------------------------------------------------
module drp_sample_responder #(
    parameter int RD_LATENCY = 4   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  daddr_in,
    input  logic        den_in,
    input  logic        dwe_in,
    input  logic [15:0] di_in,
    output logic [15:0] do_out,
    output logic        drdy_out,
    input  logic        sample_valid,
    input  logic        sample_chan,
    input  logic [11:0] sample_data,
    output logic        busy_out
);

    localparam logic [6:0] ADDR_VAUX3  = 7'h13;
    localparam logic [6:0] ADDR_VAUX11 = 7'h1B;
    localparam logic [6:0] ADDR_STATUS = 7'h3F;
    localparam logic [6:0] ADDR_CFG0   = 7'h40;
    localparam logic [6:0] ADDR_CFG1   = 7'h41;

    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [6:0]  addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;

    logic [1:0][11:0] res_q, res_d;      // index = channel
    logic [1:0][15:0] cfg_q, cfg_d;
    logic [1:0]       unread_q, unread_d;
    logic [1:0]       ovr_q, ovr_d;
    logic [15:0]      do_q, do_d;
    logic             drdy_q;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (den_in) begin
                    addr_d  = daddr_in;
                    we_d    = dwe_in;
                    wdata_d = di_in;
                    cnt_d   = CNT_LOAD;
                    state_d = (RD_LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                // Leave when the counter steps from 1 to 0 so that RESP is
                // entered RD_LATENCY-1 edges after accept; drdy_out is then
                // registered on the following edge.
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file, sample capture and overrun tracking
    // ------------------------------------------------------------------
    logic        complete;
    logic        rd_done;
    logic        wr_done;
    logic        stat_rd;
    logic [1:0]  res_rd;
    logic [1:0]  samp_wr;
    logic [15:0] rd_data;

    // The edge leaving RESP is the edge that raises drdy_out; reads and
    // writes take effect there, using register contents from before it.
    assign complete = (state_q == RESP);
    assign rd_done  = complete & ~we_q;
    assign wr_done  = complete & we_q;
    assign stat_rd  = rd_done & (addr_q == ADDR_STATUS);
    assign res_rd   = {rd_done & (addr_q == ADDR_VAUX11),
                       rd_done & (addr_q == ADDR_VAUX3)};
    assign samp_wr  = {sample_valid & sample_chan, sample_valid & ~sample_chan};

    always_comb begin
        unique case (addr_q)
            ADDR_VAUX3:  rd_data = {res_q[0], 4'b0000};
            ADDR_VAUX11: rd_data = {res_q[1], 4'b0000};
            ADDR_STATUS: rd_data = {14'b0, ovr_q};
            ADDR_CFG0:   rd_data = cfg_q[0];
            ADDR_CFG1:   rd_data = cfg_q[1];
            default:     rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        res_d    = res_q;
        cfg_d    = cfg_q;
        unread_d = unread_q;
        ovr_d    = ovr_q;
        do_d     = do_q;

        if (rd_done) begin
            do_d = rd_data;
        end
        if (wr_done) begin
            if (addr_q == ADDR_CFG0) cfg_d[0] = wdata_q;
            if (addr_q == ADDR_CFG1) cfg_d[1] = wdata_q;
        end

        // Clear-on-read first, so an overrun on the same edge wins.
        if (stat_rd) begin
            ovr_d = 2'b00;
        end

        for (int c = 0; c < 2; c++) begin
            if (samp_wr[c]) begin
                res_d[c]    = sample_data;
                unread_d[c] = 1'b1;
                // A read completing on this edge consumes the old sample,
                // so the new one does not count as overrunning it.
                if (unread_q[c] && !res_rd[c]) begin
                    ovr_d[c] = 1'b1;
                end
            end else if (res_rd[c]) begin
                unread_d[c] = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    // NOTE: the small register file is reset along with the control state,
    // since the result, config and status words must read 0 after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 7'd0;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            res_q    <= '0;
            cfg_q    <= '0;
            unread_q <= 2'b00;
            ovr_q    <= 2'b00;
            do_q     <= 16'h0000;
            drdy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            res_q    <= res_d;
            cfg_q    <= cfg_d;
            unread_q <= unread_d;
            ovr_q    <= ovr_d;
            do_q     <= do_d;
            drdy_q   <= complete;
        end
    end

    assign do_out   = do_q;
    assign drdy_out = drdy_q;
    assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_drp_sample_responder.sv
// ---------------------------------------------------------------------------
// tb_drp_sample_responder
//
// Drives two instances (RD_LATENCY 4 and 1) from the same stimulus and
// compares drdy_out, busy_out and do_out of both against a transaction-level
// model every cycle. The model tracks each request as "due at edge N" and
// applies register semantics directly. Directed sequences pin the model with
// literal expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_drp_sample_responder;

    localparam int LAT0 = 4;
    localparam int LAT1 = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  daddr = '0;
    logic        den = 1'b0;
    logic        dwe = 1'b0;
    logic [15:0] di = '0;
    logic        sample_valid = 1'b0;
    logic        sample_chan = 1'b0;
    logic [11:0] sample_data = '0;

    logic [1:0][15:0] do_out_w;
    logic [1:0]       drdy_w;
    logic [1:0]       busy_w;

    always #5 clk = ~clk;

    drp_sample_responder #(.RD_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset), .daddr_in(daddr), .den_in(den),
        .dwe_in(dwe), .di_in(di), .do_out(do_out_w[0]), .drdy_out(drdy_w[0]),
        .sample_valid(sample_valid), .sample_chan(sample_chan),
        .sample_data(sample_data), .busy_out(busy_w[0])
    );

    drp_sample_responder #(.RD_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .daddr_in(daddr), .den_in(den),
        .dwe_in(dwe), .di_in(di), .do_out(do_out_w[1]), .drdy_out(drdy_w[1]),
        .sample_valid(sample_valid), .sample_chan(sample_chan),
        .sample_data(sample_data), .busy_out(busy_w[1])
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat_of [2] = '{LAT0, LAT1};

    // Behavioural model, one copy per instance.
    logic [11:0] m_res    [2][2];
    logic [15:0] m_cfg    [2][2];
    bit          m_unread [2][2];
    bit          m_ovr    [2][2];
    bit          m_pend   [2];
    int          m_due    [2];
    logic [6:0]  m_addr   [2];
    bit          m_we     [2];
    logic [15:0] m_di     [2];
    logic [15:0] m_dout   [2];
    bit          m_drdy   [2];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                m_res[i][c] = '0; m_cfg[i][c] = '0;
                m_unread[i][c] = 0; m_ovr[i][c] = 0;
            end
            m_pend[i] = 0; m_due[i] = 0; m_addr[i] = '0; m_we[i] = 0;
            m_di[i] = '0; m_dout[i] = '0; m_drdy[i] = 0;
        end
    endtask

    // Apply one rising edge to model i, using the inputs present before it.
    task automatic model_edge(input int i);
        bit          comp;
        bit          st_rd;
        bit [1:0]    res_rd;
        logic [15:0] rdata;
        comp   = m_pend[i] && (cyc == m_due[i]);
        st_rd  = 0;
        res_rd = 2'b00;
        m_drdy[i] = comp;
        if (comp) begin
            m_pend[i] = 0;
            if (!m_we[i]) begin
                case (m_addr[i])
                    7'h13: begin rdata = {m_res[i][0], 4'h0}; res_rd[0] = 1; end
                    7'h1B: begin rdata = {m_res[i][1], 4'h0}; res_rd[1] = 1; end
                    7'h3F: begin rdata = {14'h0, m_ovr[i][1], m_ovr[i][0]}; st_rd = 1; end
                    7'h40: rdata = m_cfg[i][0];
                    7'h41: rdata = m_cfg[i][1];
                    default: rdata = 16'h0000;
                endcase
                m_dout[i] = rdata;
            end else begin
                if (m_addr[i] == 7'h40) m_cfg[i][0] = m_di[i];
                if (m_addr[i] == 7'h41) m_cfg[i][1] = m_di[i];
            end
        end else if (!m_pend[i] && den) begin
            m_pend[i] = 1;
            m_due[i]  = cyc + lat_of[i];
            m_addr[i] = daddr;
            m_we[i]   = dwe;
            m_di[i]   = di;
        end
        if (st_rd) begin
            m_ovr[i][0] = 0;
            m_ovr[i][1] = 0;
        end
        for (int c = 0; c < 2; c++) begin
            if (sample_valid && (int'(sample_chan) == c)) begin
                if (m_unread[i][c] && !res_rd[c]) m_ovr[i][c] = 1;
                m_res[i][c]    = sample_data;
                m_unread[i][c] = 1;
            end else if (res_rd[c]) begin
                m_unread[i][c] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("drdy[%0d]", i), {15'h0, drdy_w[i]}, {15'h0, m_drdy[i]});
            check($sformatf("busy[%0d]", i), {15'h0, busy_w[i]}, {15'h0, m_pend[i]});
            check($sformatf("do_out[%0d]", i), do_out_w[i], m_dout[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_do_out[%0d]", i), do_out_w[i], 16'h0000);
            check($sformatf("rst_drdy[%0d]", i), {15'h0, drdy_w[i]}, 16'h0000);
            check($sformatf("rst_busy[%0d]", i), {15'h0, busy_w[i]}, 16'h0000);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic sample(input bit ch, input logic [11:0] d);
        sample_valid = 1'b1; sample_chan = ch; sample_data = d;
        step();
        sample_valid = 1'b0;
    endtask

    // One request on an idle bus; waits (bounded) for drdy of the slower copy.
    task automatic txn(input logic [6:0] a, input bit we, input logic [15:0] d,
                       output logic [15:0] rdata, output int lat, output int busy_cnt);
        daddr = a; dwe = we; di = d; den = 1'b1;
        step();
        den = 1'b0;
        busy_cnt = int'(busy_w[0]);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (drdy_w[0]) begin
                lat = k;
                break;
            end
            if (busy_w[0]) busy_cnt++;
        end
        if (lat == 0) begin
            n_chk++; n_bad++;
            $display("FAIL txn_timeout: no drdy for addr %h within 40 cycles", a);
        end
        rdata = do_out_w[0];
    endtask

    initial begin
        logic [15:0] rd;
        int          lat;
        int          bc;
        int          nd;
        int          last;

        #3;
        do_reset();

        // Sample then read VAUX3: latency 4, busy for 4 cycles.
        sample(1'b0, 12'hABC);
        txn(7'h13, 1'b0, 16'h0, rd, lat, bc);
        check("vaux3_read", rd, 16'hABC0);
        check("vaux3_latency", 16'(lat), 16'd4);
        check("vaux3_busy_cycles", 16'(bc), 16'd4);

        // Config write/read and an unmapped address.
        txn(7'h41, 1'b1, 16'hBEEF, rd, lat, bc);
        check("cfg_write_keeps_do", rd, 16'hABC0);
        txn(7'h41, 1'b0, 16'h0, rd, lat, bc);
        check("cfg1_read", rd, 16'hBEEF);
        txn(7'h50, 1'b1, 16'h5555, rd, lat, bc);
        txn(7'h50, 1'b0, 16'h0, rd, lat, bc);
        check("unmapped_read", rd, 16'h0000);

        // Two VAUX11 samples without a read -> overrun, then cleared by read.
        sample(1'b1, 12'h111);
        sample(1'b1, 12'h222);
        txn(7'h3F, 1'b0, 16'h0, rd, lat, bc);
        check("status_overrun", rd, 16'h0002);
        txn(7'h3F, 1'b0, 16'h0, rd, lat, bc);
        check("status_cleared", rd, 16'h0000);

        // Sample on the same edge that completes a VAUX3 read.
        daddr = 7'h13; dwe = 1'b0; den = 1'b1;
        step();
        den = 1'b0;
        repeat (LAT0 - 1) step();
        sample_valid = 1'b1; sample_chan = 1'b0; sample_data = 12'h5A5;
        step();
        sample_valid = 1'b0;
        check("same_edge_drdy", {15'h0, drdy_w[0]}, 16'h0001);
        check("same_edge_old", do_out_w[0], 16'hABC0);
        txn(7'h13, 1'b0, 16'h0, rd, lat, bc);
        check("same_edge_new", rd, 16'h5A50);
        txn(7'h3F, 1'b0, 16'h0, rd, lat, bc);
        check("same_edge_no_overrun", rd, 16'h0000);

        // den held high, initiator alternating address on every drdy.
        sample(1'b0, 12'h123);
        sample(1'b1, 12'h456);
        daddr = 7'h13; dwe = 1'b0; den = 1'b1;
        nd = 0; last = 0;
        for (int k = 0; k < 80 && nd < 6; k++) begin
            step();
            if (drdy_w[0]) begin
                check("held_data", do_out_w[0], (nd % 2 == 0) ? 16'h1230 : 16'h4560);
                if (nd > 0) check("held_period", 16'(cyc - last), 16'(LAT0 + 1));
                last = cyc;
                nd++;
                daddr = (daddr == 7'h13) ? 7'h1B : 7'h13;
            end
        end
        den = 1'b0;
        check("held_count", 16'(nd), 16'd6);
        repeat (3) step();

        // Reset two cycles into a config write aborts it.
        daddr = 7'h40; dwe = 1'b1; di = 16'h1234; den = 1'b1;
        step();
        den = 1'b0;
        step();
        step();
        do_reset();
        txn(7'h40, 1'b0, 16'h0, rd, lat, bc);
        check("aborted_write", rd, 16'h0000);

        // Random traffic, with one asynchronous reset in the middle.
        for (int k = 0; k < 1500; k++) begin
            den = ($urandom_range(0, 9) < 6);
            dwe = $urandom_range(0, 1);
            di  = 16'($urandom);
            case ($urandom_range(0, 7))
                0: daddr = 7'h13;
                1: daddr = 7'h1B;
                2, 3: daddr = 7'h3F;
                4: daddr = 7'h40;
                5: daddr = 7'h41;
                default: daddr = 7'($urandom);
            endcase
            sample_valid = ($urandom_range(0, 3) == 0);
            sample_chan  = $urandom_range(0, 1);
            sample_data  = 12'($urandom);
            step();
            if (k == 700) do_reset();
        end
        den = 1'b0;
        sample_valid = 1'b0;
        repeat (LAT0 + 2) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
